// File: rtl/hex_display_pkg.sv
// hex_display_pkg
// Shared types and the nibble-to-segment table for the hex display controller.
// Segment words are active-low with bit order g..a (bit 6 = g, bit 0 = a).
package hex_display_pkg;

   typedef logic [6:0] seg_t;
   typedef logic [3:0] nibble_t;

   // All segments off.
   localparam seg_t SEG_BLANK = 7'h7F;

   // Glyphs for 0..F; index 0 is the first entry.
   localparam seg_t SEG_TABLE [16] = '{
      7'b1000000,   // 0
      7'b1111001,   // 1
      7'b0100100,   // 2
      7'b0110000,   // 3
      7'b0011001,   // 4
      7'b0010010,   // 5
      7'b0000010,   // 6
      7'b1111000,   // 7
      7'b0000000,   // 8
      7'b0010000,   // 9
      7'b0001000,   // A
      7'b0000011,   // b
      7'b1000110,   // C
      7'b0100001,   // d
      7'b0000110,   // E
      7'b0001110    // F
   };

endpackage

// File: rtl/hex_seg_lut.sv
// hex_seg_lut
// Purely combinational decoder from one hex nibble to an active-low
// 7-segment word (g..a).
// Ports:
//   i_nibble  nibble to show
//   o_seg     active-low segment pattern
module hex_seg_lut
   import hex_display_pkg::*;
(
   input  nibble_t i_nibble,
   output seg_t    o_seg
);

   assign o_seg = SEG_TABLE[i_nibble];

endmodule

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl
// Multi-digit 7-segment hex display controller. A NUM_DIGITS-nibble display
// register is loaded through a valid/ready port with a per-digit write mask.
// Every digit is decoded in parallel and driven as registered active-low
// segments, with per-digit enable and leading-zero blanking.
// Optional blinking is compiled in when the macro HEX_BLINK_EN is defined;
// otherwise there is no blink counter and i_blink_mask is ignored.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_wr_valid       write request
//   o_wr_ready       high when a write can be accepted (low for one commit
//                    cycle after every accept)
//   i_wr_data        new nibbles, digit k at [4k+3:4k]
//   i_wr_mask        1 = update digit k
//   i_digit_en       1 = digit k lit
//   i_blank_lz       1 = suppress leading zeros (digit 0 always shown)
//   i_blink_mask     1 = digit k blinks (HEX_BLINK_EN builds only)
//   o_seg            digit k segments at [7k+6:7k], g..a, active-low
module hex_display_ctrl
   import hex_display_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int BLINK_DIV  = 25000000
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_wr_valid,
   output logic                    o_wr_ready,
   input  logic [4*NUM_DIGITS-1:0] i_wr_data,
   input  logic [NUM_DIGITS-1:0]   i_wr_mask,
   input  logic [NUM_DIGITS-1:0]   i_digit_en,
   input  logic                    i_blank_lz,
   input  logic [NUM_DIGITS-1:0]   i_blink_mask,
   output logic [7*NUM_DIGITS-1:0] o_seg
);

   logic [4*NUM_DIGITS-1:0] data_q, data_d;
   logic                    wr_ready_q, wr_ready_d;
   logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
   logic                    accept_s;
   logic                    lz_run_s;
   logic [NUM_DIGITS-1:0]   lz_blank_s;
   logic [NUM_DIGITS-1:0]   blink_blank_s;
   seg_t                    lut_seg_s [NUM_DIGITS];

   assign accept_s = i_wr_valid & wr_ready_q;

   // Write port: masked nibble update and one-cycle commit after each accept.
   always_comb begin
      data_d     = data_q;
      wr_ready_d = 1'b1;
      if (accept_s) begin
         wr_ready_d = 1'b0;
         for (int k = 0; k < NUM_DIGITS; k++) begin
            if (i_wr_mask[k]) begin
               data_d[4*k +: 4] = i_wr_data[4*k +: 4];
            end else begin
               data_d[4*k +: 4] = data_q[4*k +: 4];
            end
         end
      end else begin
         wr_ready_d = 1'b1;
      end
   end

   // Leading-zero scan from the top digit; the run stops at the first
   // non-zero nibble (enable state does not matter) and never covers digit 0.
   always_comb begin
      lz_blank_s = {NUM_DIGITS{1'b0}};
      lz_run_s   = i_blank_lz;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         if (lz_run_s && (data_q[4*k +: 4] == 4'h0) && (k != 0)) begin
            lz_blank_s[k] = 1'b1;
         end else begin
            lz_run_s = 1'b0;
         end
      end
   end

`ifdef HEX_BLINK_EN
   localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

   logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             blink_phase_q, blink_phase_d;

   // Free-running blink divider; phase toggles on each wrap.
   always_comb begin
      if (blink_cnt_q == CNT_W'(BLINK_DIV - 1)) begin
         blink_cnt_d   = {CNT_W{1'b0}};
         blink_phase_d = ~blink_phase_q;
      end else begin
         blink_cnt_d   = blink_cnt_q + CNT_W'(1);
         blink_phase_d = blink_phase_q;
      end
   end

   // Blink counter and phase registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         blink_cnt_q   <= {CNT_W{1'b0}};
         blink_phase_q <= 1'b0;
      end else begin
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   assign blink_blank_s = blink_phase_q ? i_blink_mask : {NUM_DIGITS{1'b0}};
`else
   logic unused_blink_s;
   assign unused_blink_s = ^i_blink_mask;
   assign blink_blank_s  = {NUM_DIGITS{1'b0}};
`endif

   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lut
      hex_seg_lut u_lut (
         .i_nibble (data_q[4*k +: 4]),
         .o_seg    (lut_seg_s[k])
      );
   end

   // Per-digit output select: disable > leading zero > blink > glyph.
   always_comb begin
      seg_d = {NUM_DIGITS{SEG_BLANK}};
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (!i_digit_en[k]) begin
            seg_d[7*k +: 7] = SEG_BLANK;
         end else if (lz_blank_s[k]) begin
            seg_d[7*k +: 7] = SEG_BLANK;
         end else if (blink_blank_s[k]) begin
            seg_d[7*k +: 7] = SEG_BLANK;
         end else begin
            seg_d[7*k +: 7] = lut_seg_s[k];
         end
      end
   end

   // Display register, handshake flag and registered segment outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         data_q     <= {(4*NUM_DIGITS){1'b0}};
         wr_ready_q <= 1'b1;
         seg_q      <= {NUM_DIGITS{SEG_BLANK}};
      end else begin
         data_q     <= data_d;
         wr_ready_q <= wr_ready_d;
         seg_q      <= seg_d;
      end
   end

   assign o_seg      = seg_q;
   assign o_wr_ready = wr_ready_q;

endmodule
